// File: rtl/capacitoradj_pkg.sv
// Shared constants, frame FSM states and the parity helper for the capacitor trim controller.
package capacitoradj_pkg;

    localparam int CAP_CODE_W    = 3;
    localparam int CAP_POR_CODE  = 7;
    localparam int CAP_FRAME_LEN = CAP_CODE_W + 1;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        EVAL,
        RAMP
    } trim_state_t;

    // Zero-extension does not change parity, so one width serves every frame length.
    function automatic logic odd_parity(input logic [31:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/capacitoradj_trim_ramp.sv
// Purpose: holds the trim target and slews the applied code toward it one LSB per step.
// Latency: first step STEP_CYCLES edges after the target changes; steps then every STEP_CYCLES edges.
// Backpressure: none; a new target is taken at any time without restarting the step counter.
module capacitoradj_trim_ramp #(
    parameter int                CODE_W      = 3,
    parameter logic [CODE_W-1:0] POR_CODE    = '1,
    parameter int                STEP_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [CODE_W-1:0] load_code,
    output logic [CODE_W-1:0] code,
    output logic              pending_nxt
);

    localparam logic [7:0] LAST = 8'(STEP_CYCLES - 1);

    logic [CODE_W-1:0] target;
    logic [CODE_W-1:0] target_nxt;
    logic [CODE_W-1:0] code_nxt;
    logic [7:0]        cnt;
    logic [7:0]        cnt_nxt;
    logic              moving;
    logic              step;

    // Direction always comes from the target that was in force while counting,
    // so a step can only move toward a legal code and never wraps.
    always_comb begin
        target_nxt = load ? load_code : target;
        moving     = (code != target);
        step       = moving && (cnt == LAST);
        code_nxt   = code;
        cnt_nxt    = '0;
        if (moving) begin
            cnt_nxt = step ? 8'd0 : cnt + 8'd1;
        end
        if (step) begin
            code_nxt = (target > code) ? code + 1'b1 : code - 1'b1;
        end
    end

    assign pending_nxt = (code_nxt != target_nxt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            target <= POR_CODE;
            code   <= POR_CODE;
            cnt    <= '0;
        end else begin
            target <= target_nxt;
            code   <= code_nxt;
            cnt    <= cnt_nxt;
        end
    end

endmodule

// File: rtl/capacitoradj_trim_ctrl.sv
// Purpose: serial-frame trim controller driving the MIM feedback capacitor adjust code.
// Latency: ack one cycle after sen is sampled low; first code step STEP_CYCLES edges after ack.
// Backpressure: none; frames arriving under lock or malformed are dropped and flagged in frame_err.
module capacitoradj_trim_ctrl
    import capacitoradj_pkg::*;
#(
    parameter int                CODE_W      = CAP_CODE_W,
    parameter logic [CODE_W-1:0] POR_CODE    = CODE_W'(CAP_POR_CODE),
    parameter int                STEP_CYCLES = 16
) (
    input  logic              CELCLK,
    input  logic              CELRSTN,
    input  logic              sen,
    input  logic              sdi,
    input  logic              lock,
    output logic [CODE_W-1:0] capacitoradjust,
    output logic              busy,
    output logic              ack,
    output logic              frame_err
);

    localparam int              FRAME_LEN = CODE_W + (CAP_FRAME_LEN - CAP_CODE_W);
    localparam int              BC_W      = $clog2(FRAME_LEN + 2);
    localparam logic [BC_W-1:0] BC_LEN    = BC_W'(FRAME_LEN);
    localparam logic [BC_W-1:0] BC_MAX    = BC_W'(FRAME_LEN + 1);

    trim_state_t           state;
    trim_state_t           state_nxt;
    logic                  sen_d;
    logic [FRAME_LEN-1:0]  shreg;
    logic [BC_W-1:0]       bitcnt;
    logic                  eval_ok;
    logic [CODE_W-1:0]     eval_code;
    logic                  frame_end;
    logic                  load;
    logic                  pending_nxt;

    assign frame_end = sen_d & ~sen;
    assign load      = (state == EVAL) & eval_ok;

    // Verdict is latched at frame end and applied from EVAL, so a new frame may
    // start shifting on the very next edge without disturbing it.
    always_ff @(posedge CELCLK or negedge CELRSTN) begin
        if (!CELRSTN) begin
            sen_d     <= 1'b0;
            shreg     <= '0;
            bitcnt    <= '0;
            eval_ok   <= 1'b0;
            eval_code <= POR_CODE;
        end else begin
            sen_d <= sen;
            if (sen) begin
                shreg <= {shreg[FRAME_LEN-2:0], sdi};
                if (bitcnt != BC_MAX) begin
                    bitcnt <= bitcnt + 1'b1;
                end
            end else if (frame_end) begin
                bitcnt <= '0;
            end
            if (frame_end) begin
                eval_ok   <= (bitcnt == BC_LEN) && odd_parity(32'(shreg)) && !lock;
                eval_code <= shreg[FRAME_LEN-1:1];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (sen) state_nxt = SHIFT;
            SHIFT: if (!sen) state_nxt = EVAL;
            EVAL: begin
                if (sen)              state_nxt = SHIFT;
                else if (pending_nxt) state_nxt = RAMP;
                else                  state_nxt = IDLE;
            end
            RAMP: begin
                if (sen)               state_nxt = SHIFT;
                else if (!pending_nxt) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CELCLK or negedge CELRSTN) begin
        if (!CELRSTN) begin
            state     <= IDLE;
            ack       <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state <= state_nxt;
            ack   <= load;
            if (state == EVAL) begin
                frame_err <= ~eval_ok;
            end
            busy <= sen | (state_nxt == SHIFT) | (state_nxt == EVAL) | pending_nxt;
        end
    end

    capacitoradj_trim_ramp #(
        .CODE_W      (CODE_W),
        .POR_CODE    (POR_CODE),
        .STEP_CYCLES (STEP_CYCLES)
    ) u_ramp (
        .clk         (CELCLK),
        .rst_n       (CELRSTN),
        .load        (load),
        .load_code   (eval_code),
        .code        (capacitoradjust),
        .pending_nxt (pending_nxt)
    );

endmodule

// File: tb/tb_capacitoradj_trim_ctrl.sv
// Directed bench for capacitoradj_trim_ctrl with a step scoreboard checking code values and step timing.
module tb_capacitoradj_trim_ctrl;

    localparam int STEP = 16;

    logic       CELCLK = 1'b0;
    logic       CELRSTN;
    logic       sen  = 1'b0;
    logic       sdi  = 1'b0;
    logic       lock = 1'b0;
    logic [2:0] capacitoradjust;
    logic       busy;
    logic       ack;
    logic       frame_err;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int ramp_starts = 0;
    int exp_q[$];

    capacitoradj_trim_ctrl #(.STEP_CYCLES(STEP)) dut (
        .CELCLK          (CELCLK),
        .CELRSTN         (CELRSTN),
        .sen             (sen),
        .sdi             (sdi),
        .lock            (lock),
        .capacitoradjust (capacitoradjust),
        .busy            (busy),
        .ack             (ack),
        .frame_err       (frame_err)
    );

    always #5 CELCLK = ~CELCLK;
    always @(posedge CELCLK) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) else begin
            bad = bad + 1;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            sen = 1'b1;
            sdi = b[i];
            @(negedge CELCLK);
        end
        sen = 1'b0;
        sdi = 1'b0;
    endtask

    task automatic expect_ack(input logic acc);
        @(negedge CELCLK);
        chk("ack_early", ack, 0);
        @(negedge CELCLK);
        chk("ack", ack, acc);
        chk("frame_err", frame_err, !acc);
        @(negedge CELCLK);
        chk("ack_width", ack, 0);
    endtask

    task automatic wait_code(input logic [2:0] v, input int budget);
        for (int i = 0; i < budget && capacitoradjust !== v; i++) @(negedge CELCLK);
        chk("reach_code", capacitoradjust, v);
    endtask

    // Step monitor: every code change must match the scoreboard head and be on time.
    initial begin
        logic [2:0] prev_code;
        int ack_cyc, last_step_cyc, seen_starts, exp_step;
        prev_code = 3'd7;
        ack_cyc = 0;
        last_step_cyc = 0;
        seen_starts = 0;
        forever begin
            @(negedge CELCLK);
            if (CELRSTN !== 1'b1) begin
                prev_code = capacitoradjust;
            end else begin
                if (ack === 1'b1) ack_cyc = cyc;
                if (capacitoradjust !== prev_code) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_step", capacitoradjust, prev_code);
                    end else begin
                        exp_step = exp_q.pop_front();
                        chk("step_value", capacitoradjust, exp_step);
                        if (seen_starts != ramp_starts) begin
                            chk("first_step_latency", cyc - ack_cyc, STEP);
                            seen_starts = ramp_starts;
                        end else begin
                            chk("step_spacing", cyc - last_step_cyc, STEP);
                        end
                    end
                    last_step_cyc = cyc;
                    prev_code = capacitoradjust;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        CELRSTN = 1'b1;
        #1 CELRSTN = 1'b0;
        #1;
        chk("rst_code", capacitoradjust, 7);
        chk("rst_busy", busy, 0);
        chk("rst_ack", ack, 0);
        chk("rst_err", frame_err, 0);
        repeat (2) @(negedge CELCLK);
        CELRSTN = 1'b1;
        repeat (20) @(negedge CELCLK);
        chk("idle_code", capacitoradjust, 7);
        chk("idle_busy", busy, 0);
        chk("idle_err", frame_err, 0);

        // 7 -> 3
        ramp_starts++;
        exp_q.push_back(6); exp_q.push_back(5); exp_q.push_back(4); exp_q.push_back(3);
        send_frame(8'b0111, 4);
        expect_ack(1'b1);
        chk("busy_ramp", busy, 1);
        wait_code(3'd3, 100);
        chk("busy_done", busy, 0);

        // malformed frames, each followed by a clearing valid frame to the same code
        send_frame(8'b0110, 4);
        expect_ack(1'b0);
        chk("bad_parity_code", capacitoradjust, 3);
        send_frame(8'b011, 3);
        expect_ack(1'b0);
        send_frame(8'b0111, 4);
        expect_ack(1'b1);
        send_frame(8'b01110, 5);
        expect_ack(1'b0);
        send_frame(8'b0111, 4);
        expect_ack(1'b1);
        chk("same_target_idle", busy, 0);

        // lock rejects, then lock mid-ramp does not stop the ramp
        lock = 1'b1;
        send_frame(8'b0001, 4);
        expect_ack(1'b0);
        chk("locked_code", capacitoradjust, 3);
        lock = 1'b0;
        ramp_starts++;
        exp_q.push_back(2); exp_q.push_back(1); exp_q.push_back(0);
        send_frame(8'b0001, 4);
        expect_ack(1'b1);
        repeat (10) @(negedge CELCLK);
        lock = 1'b1;
        wait_code(3'd0, 100);
        chk("lock_ramp_busy", busy, 0);
        lock = 1'b0;

        // 0 -> 7, then 7 -> 0 retargeted to 6 at code 4
        ramp_starts++;
        for (int v = 1; v <= 7; v++) exp_q.push_back(v);
        send_frame(8'b1110, 4);
        expect_ack(1'b1);
        wait_code(3'd7, 200);
        ramp_starts++;
        exp_q.push_back(6); exp_q.push_back(5); exp_q.push_back(4);
        send_frame(8'b0001, 4);
        expect_ack(1'b1);
        wait_code(3'd4, 100);
        exp_q.push_back(5); exp_q.push_back(6);
        send_frame(8'b1101, 4);
        expect_ack(1'b1);
        wait_code(3'd6, 100);
        chk("retarget_busy", busy, 0);
        repeat (40) @(negedge CELCLK);
        chk("no_overshoot", capacitoradjust, 6);

        // async reset mid-ramp
        ramp_starts++;
        exp_q.push_back(5);
        send_frame(8'b0001, 4);
        expect_ack(1'b1);
        wait_code(3'd5, 100);
        repeat (3) @(negedge CELCLK);
        #2 CELRSTN = 1'b0;
        #1;
        chk("midramp_rst_code", capacitoradjust, 7);
        chk("midramp_rst_busy", busy, 0);
        exp_q.delete();
        repeat (2) @(negedge CELCLK);
        CELRSTN = 1'b1;

        // async reset mid-frame, with frame_err set beforehand
        send_frame(8'b0110, 4);
        expect_ack(1'b0);
        sen = 1'b1; sdi = 1'b1;
        @(negedge CELCLK);
        sdi = 1'b0;
        @(negedge CELCLK);
        #2 CELRSTN = 1'b0;
        #1;
        chk("midframe_rst_busy", busy, 0);
        chk("midframe_rst_err", frame_err, 0);
        chk("midframe_rst_code", capacitoradjust, 7);
        sen = 1'b0; sdi = 1'b0;
        repeat (2) @(negedge CELCLK);
        CELRSTN = 1'b1;

        ramp_starts++;
        exp_q.push_back(6); exp_q.push_back(5); exp_q.push_back(4); exp_q.push_back(3);
        send_frame(8'b0111, 4);
        expect_ack(1'b1);
        wait_code(3'd3, 100);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_err", frame_err, 0);

        chk("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
